// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead receive FIFO. The frame is pushed at tick 9 of its last stop bit.
// The drain port uses valid/ready handshaking. A frame that arrives while the FIFO is full is dropped and sets the sticky overrun flag.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 data_tx,
   input  logic [15:0]                          baud_div,
   input  logic [1:0]                           parity_type,
   input  logic                                 stop_bits,
   input  logic                                 rx_ready,
   input  logic                                 clr_err,
   output logic                                 rx_valid,
   output logic [DATA_BITS-1:0]                 rx_data,
   output logic                                 rx_parity_err,
   output logic                                 rx_frame_err,
   output logic                                 rx_break,
   output logic                                 active_flag,
   output logic                                 done_flag,
   output logic                                 overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int EW = DATA_BITS + 3;
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic                 r_sync1, r_sync2, r_prev;
   logic [2:0]           r_state;
   logic [15:0]          r_baud_cnt, r_div;
   logic [1:0]           r_par;
   logic                 r_stop;
   logic [3:0]           r_tick_cnt, r_bit_cnt;
   logic                 r_s7, r_s8;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit, r_ferr, r_any_high;
   logic [EW-1:0]        r_mem [FIFO_DEPTH];
   logic [AW:0]          r_wr_ptr, r_rd_ptr;
   logic                 r_overrun;

   logic          w_start, w_tick, w_maj, w_mid, w_end, w_par_en, w_last_stop;
   logic          w_push, w_perr, w_ferr, w_brk, w_empty, w_full, w_pop, w_wr;
   logic [EW-1:0] w_entry, w_head;

   assign w_start     = (r_state == S_IDLE) && r_prev && !r_sync2;
   assign w_tick      = (r_baud_cnt == r_div);
   assign w_maj       = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   assign w_mid       = w_tick && (r_tick_cnt == 4'd9);
   assign w_end       = w_tick && (r_tick_cnt == 4'd15);
   assign w_par_en    = (r_par == 2'b01) || (r_par == 2'b10);
   assign w_last_stop = (r_bit_cnt == {3'b000, r_stop});
   assign w_push      = (r_state == S_STOP) && w_mid && w_last_stop;
   // Odd parity expects the XOR of data and parity to be 1, even expects 0.
   assign w_perr      = w_par_en && ((^r_shift ^ r_par_bit) != (r_par == 2'b01));
   assign w_ferr      = r_ferr | ~w_maj;
   assign w_brk       = ~r_any_high & ~w_maj;
   assign w_entry     = {w_brk, w_ferr, w_perr, r_shift};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_prev     <= 1'b1;
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_div      <= '0;
         r_par      <= '0;
         r_stop     <= 1'b0;
         r_tick_cnt <= '0;
         r_bit_cnt  <= '0;
         r_s7       <= 1'b0;
         r_s8       <= 1'b0;
         r_shift    <= '0;
         r_par_bit  <= 1'b0;
         r_ferr     <= 1'b0;
         r_any_high <= 1'b0;
      end else begin
         r_sync1 <= data_tx;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (w_start) begin
            r_baud_cnt <= '0;
            r_div      <= baud_div;
            r_par      <= parity_type;
            r_stop     <= stop_bits;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_ferr     <= 1'b0;
            r_any_high <= 1'b0;
            r_state    <= S_START;
         end else begin
            r_baud_cnt <= w_tick ? 16'd0 : r_baud_cnt + 16'd1;
            if (r_state != S_IDLE && w_tick) begin
               r_tick_cnt <= r_tick_cnt + 4'd1;
               if (r_tick_cnt == 4'd7) r_s7 <= r_sync2;
               if (r_tick_cnt == 4'd8) r_s8 <= r_sync2;
            end
            case (r_state)
               S_IDLE: ;
               S_START: begin
                  if (w_mid && w_maj) r_state <= S_IDLE;
                  else if (w_end)     r_state <= S_DATA;
               end
               S_DATA: begin
                  if (w_mid) begin
                     r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                     r_any_high <= r_any_high | w_maj;
                  end
                  if (w_end) begin
                     if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt <= '0;
                        r_state   <= w_par_en ? S_PARITY : S_STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end
               S_PARITY: begin
                  if (w_mid) begin
                     r_par_bit  <= w_maj;
                     r_any_high <= r_any_high | w_maj;
                  end
                  if (w_end) r_state <= S_STOP;
               end
               S_STOP: begin
                  if (w_mid) begin
                     r_ferr     <= w_ferr;
                     r_any_high <= r_any_high | w_maj;
                     // Leave mid-bit so a back-to-back start edge is not missed.
                     if (w_last_stop) r_state <= S_IDLE;
                  end else if (w_end) begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = !w_empty && rx_ready;
   assign w_wr    = w_push && (!w_full || w_pop);
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
         else if (clr_err)               r_overrun <= 1'b0;
      end
   end

   assign rx_valid      = !w_empty;
   assign rx_data       = rx_valid ? w_head[DATA_BITS-1:0] : '0;
   assign rx_parity_err = rx_valid & w_head[DATA_BITS];
   assign rx_frame_err  = rx_valid & w_head[DATA_BITS+1];
   assign rx_break      = rx_valid & w_head[DATA_BITS+2];
   assign active_flag   = (r_state != S_IDLE);
   assign done_flag     = w_push;
   assign overrun       = r_overrun;
   assign fifo_count    = CW'(r_wr_ptr - r_rd_ptr);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are serialised onto data_tx and expected entries are checked on every pop.
module tb_uart_rx_fifo;
   localparam int DB  = 8;
   localparam int FD  = 4;
   localparam int DIV = 3;
   localparam int BIT = 16 * (DIV + 1);

   logic                      clk = 1'b0;
   logic                      rst, data_tx, stop_bits, rx_ready, clr_err;
   logic [15:0]               baud_div;
   logic [1:0]                parity_type;
   logic                      rx_valid, rx_parity_err, rx_frame_err, rx_break;
   logic                      active_flag, done_flag, overrun;
   logic [DB-1:0]             rx_data;
   logic [$clog2(FD+1)-1:0]   fifo_count;

   logic [DB+2:0] exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_done  = 0;
   int            d0;
   bit            act_seen;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) u_dut (
      .clk(clk), .rst(rst), .data_tx(data_tx), .baud_div(baud_div),
      .parity_type(parity_type), .stop_bits(stop_bits), .rx_ready(rx_ready),
      .clr_err(clr_err), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_break(rx_break), .active_flag(active_flag), .done_flag(done_flag),
      .overrun(overrun), .fifo_count(fifo_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_flag) n_done++;
      if (active_flag) act_seen = 1'b1;
      if (rx_valid && rx_ready) begin
         chk("pop_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0)
            chk("entry", {rx_break, rx_frame_err, rx_parity_err, rx_data}, exp_q.pop_front());
      end
   end

   task automatic drive(input logic v, input int n);
      data_tx = v;
      repeat (n) @(negedge clk);
   endtask

   // Correct parity is computed from the live parity_type; par_flip corrupts it.
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic [1:0] stop_lv, input logic push_exp);
      logic p, par_en, ferr;
      par_en = (parity_type == 2'b01) || (parity_type == 2'b10);
      p      = ((parity_type == 2'b01) ? ~^d : ^d) ^ par_flip;
      ferr   = !stop_lv[0] || (stop_bits && !stop_lv[1]);
      if (push_exp) exp_q.push_back({1'b0, ferr, par_en & par_flip, d});
      drive(1'b0, BIT);
      for (int i = 0; i < DB; i++) drive(d[i], BIT);
      if (par_en) drive(p, BIT);
      drive(stop_lv[0], BIT);
      if (stop_bits) drive(stop_lv[1], BIT);
      data_tx = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      chk({tag, "_drained"}, exp_q.size(), 0);
      @(negedge clk);
      chk({tag, "_valid_low"}, rx_valid, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; data_tx = 1'b1; baud_div = 16'(DIV); parity_type = 2'b10;
      stop_bits = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);
      chk("rst_active", active_flag, 0);
      chk("rst_done", done_flag, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_count", fifo_count, 0);

      // Even parity, clean frame, held in the FIFO before draining.
      d0 = n_done;
      send_frame(8'hA5, 1'b0, 2'b11, 1'b1);
      drive(1'b1, 2 * BIT);
      chk("a5_done_cnt", n_done - d0, 1);
      chk("a5_count", fifo_count, 1);
      chk("a5_valid", rx_valid, 1);
      rx_ready = 1'b1;
      wait_drain("a5");

      // Odd parity: wrong parity bit, then correct one.
      parity_type = 2'b01;
      send_frame(8'h3C, 1'b1, 2'b11, 1'b1);
      send_frame(8'h3C, 1'b0, 2'b11, 1'b1);
      drive(1'b1, BIT);
      wait_drain("odd");

      // False start: 5 ticks low.
      parity_type = 2'b00;
      d0 = n_done; act_seen = 1'b0;
      drive(1'b0, 5 * (DIV + 1));
      drive(1'b1, 3 * BIT);
      chk("fs_active_seen", act_seen, 1);
      chk("fs_done_cnt", n_done - d0, 0);
      chk("fs_count", fifo_count, 0);
      chk("fs_active_end", active_flag, 0);

      // Two stop bits: second low, then a good frame.
      stop_bits = 1'b1;
      send_frame(8'h5A, 1'b0, 2'b01, 1'b1);
      drive(1'b1, BIT);
      send_frame(8'hC3, 1'b0, 2'b11, 1'b1);
      drive(1'b1, BIT);
      wait_drain("stop2");
      stop_bits = 1'b0;

      // Break: 12 bit times low yields one entry, then normal reception resumes.
      d0 = n_done;
      exp_q.push_back({1'b1, 1'b1, 1'b0, 8'h00});
      drive(1'b0, 12 * BIT);
      drive(1'b1, 2 * BIT);
      chk("brk_done_cnt", n_done - d0, 1);
      send_frame(8'h96, 1'b0, 2'b11, 1'b1);
      drive(1'b1, BIT);
      chk("brk_after_done_cnt", n_done - d0, 2);
      wait_drain("brk");

      // Overrun: five back-to-back frames into a 4-deep FIFO.
      rx_ready = 1'b0;
      for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 2'b11, v <= 4);
      drive(1'b1, BIT);
      chk("ovr_count", fifo_count, 4);
      chk("ovr_flag", overrun, 1);
      rx_ready = 1'b1;
      wait_drain("ovr");
      chk("ovr_sticky", overrun, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("ovr_cleared", overrun, 0);

      // Reset in mid-frame discards the partial frame.
      rx_ready = 1'b0;
      d0 = n_done;
      drive(1'b0, 3 * BIT);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_active", active_flag, 0);
      rst = 1'b0;
      drive(1'b1, 3 * BIT);
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_done_cnt", n_done - d0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
